// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
// Shared definitions for the period meter: the measurement FSM state type,
// the minimum synchroniser depth, and a helper that clamps a requested
// synchroniser depth to that minimum.
// -----------------------------------------------------------------------------
package period_meter_pkg;

  // Measurement sequencing:
  //   IDLE    - disabled, counters parked at zero
  //   ARM     - enabled, waiting for the first rising edge to start timing
  //   MEASURE - timing the interval between consecutive rising edges
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  // Two flops is the least that gives metastability a full cycle to settle.
  localparam int SYNC_STAGES_MIN = 2;

  // Depth actually built: a request below the minimum is raised to it.
  function automatic int clamp_sync_stages(input int requested);
    return (requested < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : requested;
  endfunction

endpackage : period_meter_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a chain of
// synchroniser flops, then compares the synchronised level with a one-cycle
// history copy to produce single-cycle rise and fall strobes.
//
// Parameters
//   SYNC_STAGES  number of synchroniser flops (raised to the package minimum)
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears every flop
//   d     in   asynchronous input level
//   rise  out  one-cycle strobe: synchronised level went 0 -> 1
//   fall  out  one-cycle strobe: synchronised level went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge_det
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  localparam int STAGES = clamp_sync_stages(SYNC_STAGES);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              sync_lvl;

  assign sync_lvl = sync_q[STAGES-1];

  // Synchroniser chain shifts toward the MSB; the history flop holds the
  // previous synchronised level so an edge is visible for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_lvl;
    end
  end

  // Strobes are combinational so the consumer acts on them at the very next
  // edge, keeping the overall input-to-output latency at STAGES cycles.
  assign rise = sync_lvl & ~hist_q;
  assign fall = ~sync_lvl & hist_q;

endmodule : sync_edge_det

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the period and high time of sig_in in clk cycles. Each qualifying
// rising edge publishes the interval since the previous rising edge together
// with how long the signal was high in that interval, and pulses
// period_valid. If no rising edge arrives before the counter would run out,
// timeout is set (sticky until the next good measurement) and the meter
// re-arms.
//
// Parameters
//   CNT_W        width of the counters and of period/high_time
//   SYNC_STAGES  synchroniser depth on sig_in
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset, highest priority
//   en            in   level-sensitive measurement enable
//   sig_in        in   measured signal, may be asynchronous to clk
//   period        out  clk cycles between the last two sig_in rising edges
//   high_time     out  clk cycles sig_in was high within that period
//   period_valid  out  one-cycle pulse when period/high_time update
//   timeout       out  sticky: no rising edge within the counter range
// -----------------------------------------------------------------------------
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Last count value from which a rise still yields a representable period
  // (cnt + 1 = 2^CNT_W - 1); reaching it without a rise is a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  meter_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic             rise;
  logic             fall;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise),
    .fall (fall)
  );

  // Measurement FSM with registered outputs. Priority order is reset, then
  // enable, then edge strobes, so dropping en in the same cycle as a rise
  // discards that rise. cnt counts cycles since the last rise minus one, so
  // the published values are cnt + 1 at the closing rise (period) and at the
  // fall (high time). period, high_time and timeout are left untouched when
  // the meter is disabled so software can still read the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_cap       <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        hi_cap <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt    <= '0;
            hi_cap <= '0;
            state  <= ARM;
          end

          ARM: begin
            if (rise) begin
              cnt   <= '0;
              state <= MEASURE;
            end
          end

          MEASURE: begin
            if (rise) begin
              period       <= cnt + CNT_ONE;
              high_time    <= hi_cap;
              period_valid <= 1'b1;
              timeout      <= 1'b0;
              cnt          <= '0;
            end else if (cnt == CNT_LAST) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                hi_cap <= cnt + CNT_ONE;
              end
            end
          end

          default: begin
            cnt    <= '0;
            hi_cap <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : period_meter

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
// Self-checking bench for period_meter (CNT_W = 8 so the timeout range is
// short). The reference model works on timestamps: it remembers the edge
// number of the last rising and falling edge of the delayed input and derives
// period and high time by subtraction.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_PERIOD  = (1 << CNT_W) - 1;
  localparam int HIST        = 32768;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;

  int compared   = 0;
  int mismatched = 0;

  int cycle      = 0;
  int last_reset = 0;
  bit samp [HIST];

  bit m_armed     = 1'b0;
  bit m_measuring = 1'b0;
  int m_rise_at   = 0;
  int m_fall_at   = 0;
  int exp_period  = 0;
  int exp_high    = 0;
  bit exp_valid   = 1'b0;
  bit exp_timeout = 1'b0;

  always #5 clk = ~clk;

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // sig_in as seen at edge idx; flops cleared by reset read back as 0.
  function automatic bit sampAt(input int idx);
    if (idx <= last_reset || idx < 0) return 1'b0;
    return samp[idx];
  endfunction

  // Reference behaviour at edge 'cycle'. An input edge sampled at edge k acts
  // at edge k + SYNC_STAGES.
  task automatic modelStep(input bit r, input bit e);
    bit rise_now;
    bit fall_now;
    exp_valid = 1'b0;
    if (r) begin
      m_armed     = 1'b0;
      m_measuring = 1'b0;
      exp_period  = 0;
      exp_high    = 0;
      exp_timeout = 1'b0;
      m_fall_at   = 0;
      m_rise_at   = 0;
      last_reset  = cycle;
      return;
    end
    rise_now = sampAt(cycle - SYNC_STAGES) && !sampAt(cycle - SYNC_STAGES - 1);
    fall_now = !sampAt(cycle - SYNC_STAGES) && sampAt(cycle - SYNC_STAGES - 1);
    if (!e) begin
      m_armed     = 1'b0;
      m_measuring = 1'b0;
    end else if (!m_armed && !m_measuring) begin
      m_armed = 1'b1;
    end else if (m_armed) begin
      if (rise_now) begin
        m_armed     = 1'b0;
        m_measuring = 1'b1;
        m_rise_at   = cycle;
        m_fall_at   = cycle;
      end
    end else begin
      if (rise_now) begin
        exp_period  = cycle - m_rise_at;
        exp_high    = m_fall_at - m_rise_at;
        exp_valid   = 1'b1;
        exp_timeout = 1'b0;
        m_rise_at   = cycle;
        m_fall_at   = cycle;
      end else if (cycle - m_rise_at == MAX_PERIOD) begin
        exp_timeout = 1'b1;
        m_measuring = 1'b0;
        m_armed     = 1'b1;
      end else if (fall_now) begin
        m_fall_at = cycle;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and check all outputs.
  task automatic applyStimulus(input bit s, input bit e, input bit r);
    @(negedge clk);
    sig_in = s;
    en     = e;
    rst    = r;
    @(posedge clk);
    cycle++;
    samp[cycle] = s;
    modelStep(r, e);
    #1;
    checkOutput("period",       32'(period),       32'(exp_period));
    checkOutput("high_time",    32'(high_time),    32'(exp_high));
    checkOutput("period_valid", 32'(period_valid), 32'(exp_valid));
    checkOutput("timeout",      32'(timeout),      32'(exp_timeout));
  endtask

  initial begin
    int level;
    int remain;
    int en_off;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 48; i++) applyStimulus((i % 4) < 2, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) applyStimulus((i % 10) < 3, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++)
      applyStimulus((i % 10) < 3, !(i >= 14 && i < 19), 1'b0);

    for (int i = 0; i < 4; i++)   applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 48; i++)  applyStimulus((i % 8) < 4, 1'b1, 1'b0);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++)   applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 252; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++)   applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 253; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 14; i++) applyStimulus((i % 4) < 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus((i % 4) < 2, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) applyStimulus((i % 6) < 3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < SYNC_STAGES; j++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus((i % 6) < 3, 1'b1, 1'b0);

    level  = 0;
    remain = 3;
    en_off = 0;
    for (int i = 0; i < 3000; i++) begin
      if (remain == 0) begin
        level  = 1 - level;
        remain = ($urandom_range(0, 39) == 0) ? $urandom_range(200, 300)
                                              : $urandom_range(2, 25);
      end
      remain--;
      if (en_off == 0 && $urandom_range(0, 199) == 0) en_off = $urandom_range(1, 8);
      applyStimulus(level[0], en_off == 0, $urandom_range(0, 599) == 0);
      if (en_off > 0) en_off--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_period_meter

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchroniser flops on sig_in.
REQ-003 clk  input  1  single clock; all logic is rising-edge of clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  measurement enable, level-sensitive.
REQ-006 sig_in  input  1  measured signal, typically a divided clock; may be asynchronous to clk.
REQ-007 period  output  CNT_W  clk cycles between the last two sig_in rising edges.
REQ-008 high_time  output  CNT_W  clk cycles sig_in was high within that period.
REQ-009 period_valid  output  1  one-cycle pulse when period and high_time update.
REQ-010 timeout  output  1  sticky flag: no rising edge seen within the counter range.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-012 An edge first sampled at clk edge k SHALL produce its rise/fall strobe in the cycle after edge k+SYNC_STAGES-1; registered outputs SHALL update at edge k+SYNC_STAGES.
REQ-013 The FSM SHALL have three states: IDLE, ARM and MEASURE.
REQ-014 IDLE: counters held at 0; en=1 SHALL move the FSM to ARM.
REQ-015 ARM: rise SHALL clear cnt to 0 and move to MEASURE; no period_valid is produced for this first edge; fall is ignored.
REQ-016 MEASURE: cnt SHALL increment by 1 every cycle without rise; fall SHALL capture hi_cap = cnt+1.
REQ-017 MEASURE rise SHALL do all of the following in one cycle: period = cnt+1, high_time = hi_cap, period_valid = 1, cnt = 0, timeout = 0; the FSM stays in MEASURE.
REQ-018 MEASURE with cnt == 2^CNT_W-2 and no rise SHALL set timeout=1 and move to ARM with cnt cleared; no period_valid is produced. Maximum measurable period is 2^CNT_W-1.
REQ-019 en=0 in any state SHALL move the FSM to IDLE at the next edge and clear cnt and hi_cap; period, high_time and timeout hold their values.
REQ-020 If en falls in the same cycle as a rise, en SHALL win: no period_valid, FSM goes to IDLE.
REQ-021 period_valid SHALL be high for exactly one cycle per qualifying rise and never in back-to-back cycles.
REQ-022 sig_in levels SHALL be held at least 2 clk cycles to be measured; narrower pulses may be missed, with no further guarantee.
REQ-023 All arithmetic SHALL be unsigned CNT_W-bit; no wrap is possible because of REQ-018.

Reset
REQ-024 rst=1 SHALL, at the next clk edge, set: period=0, high_time=0, period_valid=0, timeout=0, cnt=0, hi_cap=0, FSM=IDLE, synchroniser and history flops=0.
REQ-025 rst SHALL take priority over en and over any edge strobe, including mid-measurement.

Structure
REQ-026 Package period_meter_pkg SHALL hold the FSM state type (IDLE/ARM/MEASURE) and the SYNC_STAGES minimum constant.
REQ-027 The synchroniser plus edge detector SHALL be the sub-module sync_edge_det (params SYNC_STAGES; ports clk, rst, d, rise, fall); everything else lives in period_meter.

Verification
REQ-028 sig_in = same-clock divide-by-4 square wave, en=1 -> first period_valid after 2nd rise; then period=4, high_time=2, valid every 4 cycles.
REQ-029 sig_in high 3 / low 7 cycles, repeating -> period=10, high_time=3 on every valid.
REQ-030 CNT_W=8, sig_in held low after one rise -> timeout=1 after 254 cycles in MEASURE with no valid; toggling resumes -> timeout clears at the first valid (2nd rise after re-arm).
REQ-031 en dropped for 5 cycles mid-period, then restored -> no valid for the partial period, outputs hold, next valid only after 2 rises post re-enable.
REQ-032 rst pulsed mid-measurement -> all outputs 0 at the next edge, FSM in IDLE, normal measurement after release.
REQ-033 en falls in the same cycle as a rise strobe -> no period_valid, FSM in IDLE.
